instr_fetch_unit: RTL

Instruction fetch stage between the program counter and the decode stage of the CPU. It issues word reads to instruction memory at the current PC and tells the PC register when to advance. It also buffers returned instructions with their PCs in a 2-entry queue for decode. A flush input discards queued and in-flight instructions when control flow is redirected.

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads at the current PC under a credit limit
// and queues returned {inst, pc} pairs for decode; flush drops queued and in-flight words.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misaligned
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [CNT_W-1:0]  outstanding, discard, count;
  logic [CNT_W-1:0]  outstanding_nxt, discard_nxt, count_nxt;
  logic [ADDR_W-1:0] req_pc_mem [DEPTH];
  logic [PTR_W-1:0]  req_wr_ptr, req_rd_ptr;
  entry_t            dq_mem [DEPTH];
  logic [PTR_W-1:0]  dq_wr_ptr, dq_rd_ptr;
  logic              aligned, grant, push, pop, drop_dec;
  logic [CNT_W:0]    in_use;

  assign aligned    = (pc[1:0] == 2'b00);
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready & ~flush;
  assign drop_dec   = imem_rvalid & (discard != '0);
  assign push       = imem_rvalid & ~flush & (discard == '0);

  // A slot freed by this cycle's decode pop is lent to a new request, which is what
  // sustains one fetch per cycle; the sum can never exceed DEPTH after the edge.
  assign in_use = (CNT_W + 1)'(outstanding) + (CNT_W + 1)'(count) - (CNT_W + 1)'(pop);

  assign imem_req   = ~reset & ~flush & ~misaligned & aligned & (in_use < CREDITS);
  assign imem_addr  = pc;
  assign grant      = imem_req & imem_gnt;
  assign pc_advance = grant;

  assign inst    = inst_valid ? dq_mem[dq_rd_ptr].inst : '0;
  assign inst_pc = inst_valid ? dq_mem[dq_rd_ptr].pc   : '0;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
    count_nxt       = count + CNT_W'(push) - CNT_W'(pop);
    discard_nxt     = discard - CNT_W'(drop_dec);
    if (flush) begin
      count_nxt   = '0;
      // outstanding already counts the responses still owed to discard.
      discard_nxt = outstanding - CNT_W'(imem_rvalid);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      misaligned  <= 1'b0;
      req_wr_ptr  <= '0;
      req_rd_ptr  <= '0;
      dq_wr_ptr   <= '0;
      dq_rd_ptr   <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      count       <= count_nxt;
      misaligned  <= flush ? 1'b0 : (misaligned | ~aligned);
      if (grant)       req_wr_ptr <= req_wr_ptr + PTR_W'(1);
      if (imem_rvalid) req_rd_ptr <= req_rd_ptr + PTR_W'(1);
      if (flush) begin
        dq_wr_ptr <= '0;
        dq_rd_ptr <= '0;
      end else begin
        if (push) dq_wr_ptr <= dq_wr_ptr + PTR_W'(1);
        if (pop)  dq_rd_ptr <= dq_rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; the counters and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (grant) req_pc_mem[req_wr_ptr] <= pc;
    if (push)  dq_mem[dq_wr_ptr] <= '{inst: imem_rdata, pc: req_pc_mem[req_rd_ptr]};
  end

endmodule
